botupdt_handshake_n: RTL

//  N-channel successor to the single BotUpdt/INT_ACK set-clear handshake flop between rojobot instances and the SweRVolf core.
//  Per channel: synchronise the raw update strobe, detect its rising edge, set a sticky pending flag and freeze a coherent info snapshot.

---
 rtl/botupdt_handshake_n.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/botupdt_handshake_n.sv
// N-channel BotUpdt set/clear handshake: synchronised update edge -> sticky pend + coherent snapshot.
// Optional saturating overflow counters enabled by defining BOTUPDT_OVF_CNT_EN.
module botupdt_handshake_n #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned DW          = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned OVF_W       = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NCH-1:0]       i_upd,
   input  logic [NCH*DW-1:0]    i_info,
   input  logic [NCH-1:0]       i_en,
   input  logic [NCH-1:0]       i_ack,
   input  logic [NCH-1:0]       i_ovf_clr,
   output logic [NCH-1:0]       o_pend,
   output logic [NCH*DW-1:0]    o_info,
   output logic                 o_irq,
   output logic [NCH-1:0]       o_ovf,
   output logic [NCH*OVF_W-1:0] o_ovf_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

   logic [SYNC_STAGES-1:0] r_sync [NCH];
   logic [NCH-1:0]         r_sd;
   logic [NCH-1:0]         w_s;
   logic [NCH-1:0]         w_evt;

   state_t                 r_state     [NCH];
   state_t                 w_state_nxt [NCH];
   logic [DW-1:0]          r_info      [NCH];
   logic [DW-1:0]          w_info_nxt  [NCH];
   logic [NCH-1:0]         r_ovf;
   logic [NCH-1:0]         w_ovf_nxt;
   logic [NCH-1:0]         w_ovf_evt;

   // Synchroniser chain plus one delayed copy for rising-edge detection
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NCH; i++) r_sync[i] <= '0;
         r_sd <= '0;
      end else begin
         for (int i = 0; i < NCH; i++)
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], i_upd[i]};
         r_sd <= w_s;
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) w_s[i] = r_sync[i][SYNC_STAGES-1];
      w_evt = w_s & ~r_sd;
   end

   // Per-channel state, snapshot and overflow registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= ST_IDLE;
            r_info[i]  <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_info[i]  <= w_info_nxt[i];
         end
         r_ovf <= w_ovf_nxt;
      end
   end

   // Next state: an ack always wins over an overflow; a disabled event is invisible
   always_comb begin
      w_ovf_evt = '0;
      w_ovf_nxt = r_ovf & ~i_ovf_clr;
      for (int i = 0; i < NCH; i++) begin
         w_state_nxt[i] = r_state[i];
         w_info_nxt[i]  = r_info[i];
      end
      for (int i = 0; i < NCH; i++) begin
         case (r_state[i])
            ST_IDLE: begin
               if (w_evt[i] && i_en[i]) begin
                  w_state_nxt[i] = ST_PEND;
                  w_info_nxt[i]  = i_info[i*DW +: DW];
               end
            end
            ST_PEND: begin
               if (i_ack[i]) begin
                  if (w_evt[i] && i_en[i]) w_info_nxt[i]  = i_info[i*DW +: DW];
                  else                     w_state_nxt[i] = ST_IDLE;
               end else if (w_evt[i] && i_en[i]) begin
                  w_ovf_evt[i] = 1'b1;
                  w_ovf_nxt[i] = 1'b1;
               end
            end
            default: w_state_nxt[i] = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         o_pend[i]           = (r_state[i] == ST_PEND);
         o_info[i*DW +: DW]  = r_info[i];
      end
   end

   assign o_ovf = r_ovf;
   assign o_irq = |o_pend;

`ifdef BOTUPDT_OVF_CNT_EN
   logic [OVF_W-1:0] r_cnt      [NCH];
   logic [OVF_W-1:0] w_cnt_base [NCH];
   logic [OVF_W-1:0] w_cnt_nxt  [NCH];

   // Clear applies before the increment so a coinciding overflow leaves a count of one
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_cnt_base[i] = i_ovf_clr[i] ? '0 : r_cnt[i];
         w_cnt_nxt[i]  = w_cnt_base[i];
         if (w_ovf_evt[i] && (w_cnt_base[i] != '1))
            w_cnt_nxt[i] = w_cnt_base[i] + OVF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) o_ovf_cnt[i*OVF_W +: OVF_W] = r_cnt[i];
   end
`else
   assign o_ovf_cnt = '0;
`endif

endmodule
